reg_bank_wb_arbiter: RTL

//  Write-port arbiter and scoreboard for the RV32I register bank.
//  - Shares the single register-bank write port between the ALU and LSU writeback sources.
//  - Tracks outstanding destination registers in a 32-bit busy mask.
//  - Stalls decode on RAW/WAW hazards.
//  - Sits between decode/execute and the register bank write port (rf_wr_*).

---
 rtl/reg_bank_wb_arbiter_pkg.sv | 16 +
 rtl/reg_bank_wb_arbiter_rr_arb2.sv | 39 +++
 rtl/reg_bank_wb_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/reg_bank_wb_arbiter_pkg.sv
// Shared definitions for the register-bank writeback arbiter: size defaults,
// the hardwired-zero register index and the writeback source encoding.
package reg_bank_wb_arbiter_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int REG_X0       = 0;

  // Encoding shared with execute; also the meaning of the RR pointer.
  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

endpackage

// File: rtl/reg_bank_wb_arbiter_rr_arb2.sv
// Two-request round-robin arbiter (ALU vs LSU) with a last-granted pointer.
// Grants are combinational; the pointer moves only when a grant is issued.
module reg_bank_rr_arb2
  import reg_bank_wb_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu,
  output logic gnt_src
);

  wb_src_e last_q;
  wb_src_e last_d;

  always_comb begin
    gnt_alu = req_alu & (~req_lsu | (last_q == SRC_LSU));
    gnt_lsu = req_lsu & ~gnt_alu;
    gnt_src = gnt_lsu;
    last_d  = last_q;
    if (gnt_alu) begin
      last_d = SRC_ALU;
    end else if (gnt_lsu) begin
      last_d = SRC_LSU;
    end
  end

  // Reset to LSU so the ALU wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SRC_LSU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_bank_wb_arbiter.sv
// RV32I register-bank write-port arbiter and busy-mask scoreboard.
// Optional operand forwarding of the granted writeback: REG_BANK_WB_BYPASS_EN.
module reg_bank_wb_arbiter
  import reg_bank_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                reg_clk,
  input  logic                reg_rst_n,
  input  logic                issue_valid,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  input  logic [ADDR_W-1:0]   issue_rd,
  output logic                issue_stall,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_rd,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                lsu_wb_valid,
  input  logic [ADDR_W-1:0]   lsu_wb_rd,
  input  logic [DATA_W-1:0]   lsu_wb_data,
  output logic                lsu_wb_ready,
  output logic                rf_wr_en,
  output logic [ADDR_W-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_err
`ifdef REG_BANK_WB_BYPASS_EN
  ,
  output logic                fwd_rs1_en,
  output logic                fwd_rs2_en,
  output logic [DATA_W-1:0]   fwd_data
`endif
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_X0);

  logic                gnt_alu, gnt_lsu, gnt_src, gnt_any;
  logic [ADDR_W-1:0]   gnt_rd;
  logic [DATA_W-1:0]   gnt_data;
  logic                busy_rs1, busy_rs2, busy_rd;
  logic                haz_rs1, haz_rs2;
  logic                issue_acc;

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                wb_err_q, wb_err_d;
  logic                rf_wr_en_q, rf_wr_en_d;
  logic [ADDR_W-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_W-1:0]   rf_wr_data_q, rf_wr_data_d;

  reg_bank_rr_arb2 u_arb (
    .clk     (reg_clk),
    .rst_n   (reg_rst_n),
    .req_alu (alu_wb_valid),
    .req_lsu (lsu_wb_valid),
    .gnt_alu (gnt_alu),
    .gnt_lsu (gnt_lsu),
    .gnt_src (gnt_src)
  );

  always_comb begin
    gnt_any  = gnt_alu | gnt_lsu;
    gnt_rd   = gnt_src ? lsu_wb_rd   : alu_wb_rd;
    gnt_data = gnt_src ? lsu_wb_data : alu_wb_data;

    // x0 never reports busy, whatever the mask holds.
    busy_rs1 = (issue_rs1 != X0) & busy_q[issue_rs1];
    busy_rs2 = (issue_rs2 != X0) & busy_q[issue_rs2];
    busy_rd  = (issue_rd  != X0) & busy_q[issue_rd];

`ifdef REG_BANK_WB_BYPASS_EN
    // Source hazards vanish when the pending value is on the write port now;
    // the WAW hazard on rd is never waived.
    fwd_rs1_en = gnt_any & (gnt_rd == issue_rs1) & (issue_rs1 != X0);
    fwd_rs2_en = gnt_any & (gnt_rd == issue_rs2) & (issue_rs2 != X0);
    fwd_data   = gnt_data;
    haz_rs1    = busy_rs1 & ~fwd_rs1_en;
    haz_rs2    = busy_rs2 & ~fwd_rs2_en;
`else
    haz_rs1    = busy_rs1;
    haz_rs2    = busy_rs2;
`endif

    issue_stall  = issue_valid & (haz_rs1 | haz_rs2 | busy_rd);
    issue_acc    = issue_valid & ~issue_stall;
    alu_wb_ready = gnt_alu;
    lsu_wb_ready = gnt_lsu;

    busy_d       = busy_q;
    wb_err_d     = wb_err_q;
    rf_wr_en_d   = 1'b0;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_wr_data_d = rf_wr_data_q;

    if (gnt_any) begin
      rf_wr_addr_d = gnt_rd;
      rf_wr_data_d = gnt_data;
      if (gnt_rd != X0) begin
        rf_wr_en_d = 1'b1;
        if (!busy_q[gnt_rd]) begin
          wb_err_d = 1'b1;
        end
        busy_d[gnt_rd] = 1'b0;
      end
    end

    // Applied after the clear: a same-register set can only follow an
    // unexpected writeback, and the new outstanding write must be kept.
    if (issue_acc && (issue_rd != X0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[REG_X0] = 1'b0;
  end

  always_ff @(posedge reg_clk or negedge reg_rst_n) begin
    if (!reg_rst_n) begin
      busy_q       <= '0;
      wb_err_q     <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_wr_data_q <= '0;
    end else begin
      busy_q       <= busy_d;
      wb_err_q     <= wb_err_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
    end
  end

  assign busy_mask  = busy_q;
  assign wb_err     = wb_err_q;
  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_wr_data = rf_wr_data_q;

endmodule
